// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared widths and drain sequencer state encoding for the PE array result path.
package pe_array_pkg;
  localparam int DATA_W = 32;
  localparam int POS_W = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, DONE} drain_state_t;
endpackage

// File: rtl/pe_array_drain.sv
// pe_array_drain: scans every PE position, reads its result after RD_LAT cycles and streams it out tagged with (x, y).
module pe_array_drain #(
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int DATA_W = pe_array_pkg::DATA_W,
  parameter int POS_W = pe_array_pkg::POS_W,
  parameter int RD_LAT = 1
) (
  input  logic              master_clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  x_position,
  output logic [POS_W-1:0]  y_position,
  output logic              rdn,
  input  logic [DATA_W-1:0] output_value,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [POS_W-1:0]  m_x,
  output logic [POS_W-1:0]  m_y,
  output logic              m_last
);
  import pe_array_pkg::*;
  localparam int LAT_W = $clog2(RD_LAT + 1) + 1;
  localparam logic [LAT_W-1:0] LAT = LAT_W'(RD_LAT);
  localparam logic [POS_W-1:0] X_MAX = POS_W'(COLS - 1);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(ROWS - 1);
  drain_state_t state, state_n;
  logic [LAT_W-1:0] lat_cnt;
  logic capture, xfer, last_pos;
  always_comb begin
    last_pos = x_position == X_MAX && y_position == Y_MAX;
    xfer = state == PUSH && m_ready;
    capture = (state == ISSUE && RD_LAT == 0) || (state == WAIT && lat_cnt == LAT);
    state_n = state;
    case (state)
      IDLE:    state_n = start ? ISSUE : IDLE;
      ISSUE:   state_n = RD_LAT == 0 ? PUSH : WAIT;
      WAIT:    state_n = capture ? PUSH : WAIT;
      PUSH:    state_n = xfer ? (m_last ? DONE : ISSUE) : PUSH;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge master_clock) begin
    if (reset) begin
      state <= IDLE;
      lat_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rdn <= 1'b1;
      m_valid <= 1'b0;
      x_position <= '0;
      y_position <= '0;
      m_data <= '0;
      m_x <= '0;
      m_y <= '0;
      m_last <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      rdn <= !(state_n == ISSUE || state_n == WAIT);
      m_valid <= state_n == PUSH;
      lat_cnt <= state == WAIT ? lat_cnt + 1'b1 : LAT_W'(1);
      if (state == IDLE && start) begin
        x_position <= '0;
        y_position <= '0;
      end else if (xfer && !m_last) begin
        x_position <= x_position == X_MAX ? '0 : x_position + 1'b1;
        y_position <= x_position == X_MAX ? y_position + 1'b1 : y_position;
      end
      if (capture) begin
        m_data <= output_value;
        m_x <= x_position;
        m_y <= y_position;
        m_last <= last_pos;
      end
    end
  end
endmodule

// File: tb/tb_pe_array_drain.sv
// tb_pe_array_drain: four drain instances (4x4 lat 1/0/3 and 1x1 lat 1) against a PE model and beat-order scoreboard.
module tb_pe_array_drain;
  localparam int NI = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic [NI-1:0] start, m_ready, busy, done, rdn, m_valid, m_last;
  logic [NI-1:0][7:0] x_position, y_position, m_x, m_y;
  logic [NI-1:0][31:0] output_value, m_data;
  int checks = 0;
  int errors = 0;
  logic [31:0] bdata [16];
  logic [15:0] blast;
  function automatic int cols(input int i);
    return i == 3 ? 1 : 4;
  endfunction
  function automatic logic [31:0] val(input logic [7:0] x, input logic [7:0] y);
    return 32'h3FEF5C29 + {16'h0, y, x};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // PE model: the result is valid only in the cycle exactly L cycles after rdn fell; garbage otherwise.
  for (genvar g = 0; g < NI; g++) begin : u
    localparam int C = g == 3 ? 1 : 4;
    localparam int L = g == 1 ? 0 : g == 2 ? 3 : 1;
    int k = 0;
    always @(posedge clk) k <= rdn[g] ? 0 : k + 1;
    assign output_value[g] = (!rdn[g] && k == L) ? val(x_position[g], y_position[g]) : 32'hDEADBEEF;
    pe_array_drain #(.COLS(C), .ROWS(C), .DATA_W(32), .POS_W(8), .RD_LAT(L)) dut (
      .master_clock(clk), .reset(reset), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .x_position(x_position[g]), .y_position(y_position[g]), .rdn(rdn[g]),
      .output_value(output_value[g]), .m_valid(m_valid[g]), .m_ready(m_ready[g]),
      .m_data(m_data[g]), .m_x(m_x[g]), .m_y(m_y[g]), .m_last(m_last[g]));
  end
  // Scoreboard: beat idx must be position (idx % cols, idx / cols) in raster order, one per transfer.
  int idx [NI];
  always @(negedge clk) begin
    int c;
    for (int i = 0; i < NI; i++) begin
      c = cols(i);
      if (reset) idx[i] = 0;
      else begin
        if (m_valid[i]) begin
          chk("beat_x", m_x[i], idx[i] % c);
          chk("beat_y", m_y[i], idx[i] / c);
          chk("beat_data", m_data[i], val(8'(idx[i] % c), 8'(idx[i] / c)));
          chk("beat_last", m_last[i], idx[i] == c * c - 1);
          chk("push_rdn", rdn[i], 1);
          if (m_ready[i]) idx[i]++;
        end
        if (!rdn[i]) begin
          chk("read_x", x_position[i], idx[i] % c);
          chk("read_y", y_position[i], idx[i] / c);
          chk("read_busy", busy[i], 1);
        end
        if (!busy[i]) begin
          chk("idle_rdn", rdn[i], 1);
          chk("idle_valid", m_valid[i], 0);
        end
        if (done[i]) begin
          chk("done_beats", idx[i], c * c);
          idx[i] = 0;
        end
      end
    end
  end
  task automatic scan(input int i, input int stall_beat, input int poke_beat,
                      output int done_c, output int nb, output int first_c, output int last_c);
    int c;
    logic [31:0] sd;
    logic [7:0] sx, sy, px, py;
    logic sl;
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
    chk("scan_busy", busy[i], 1);
    chk("scan_rdn", rdn[i], 0);
    chk("scan_x0", x_position[i], 0);
    chk("scan_y0", y_position[i], 0);
    c = 1; nb = 0; done_c = -1; first_c = -1; last_c = -1; blast = '0;
    while (c < 200) begin
      if (done[i]) begin
        done_c = c;
        break;
      end
      if (m_valid[i]) begin
        if (nb == stall_beat) begin
          sd = m_data[i]; sx = m_x[i]; sy = m_y[i]; sl = m_last[i];
          px = x_position[i]; py = y_position[i];
          m_ready[i] = 1'b0;
          repeat (5) begin
            step();
            c++;
            chk("stall_valid", m_valid[i], 1);
            chk("stall_data", m_data[i], sd);
            chk("stall_mx", m_x[i], sx);
            chk("stall_my", m_y[i], sy);
            chk("stall_last", m_last[i], sl);
            chk("stall_rdn", rdn[i], 1);
            chk("stall_px", x_position[i], px);
            chk("stall_py", y_position[i], py);
          end
          m_ready[i] = 1'b1;
        end
        if (nb == poke_beat) start[i] = 1'b1;
        if (nb < 16) begin
          bdata[nb] = m_data[i];
          blast[nb] = m_last[i];
        end
        if (nb == 0) first_c = c;
        last_c = c;
        nb++;
      end
      step();
      start[i] = 1'b0;
      c++;
    end
  endtask
  initial begin
    int dc, nb, fc, lc;
    reset = 1'b1;
    start = '0;
    m_ready = '1;
    repeat (3) step();
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_x", x_position[0], 0);
    chk("rst_y", y_position[0], 0);
    chk("rst_rdn", rdn[0], 1);
    chk("rst_valid", m_valid[0], 0);
    chk("rst_data", m_data[0], 0);
    chk("rst_mx", m_x[0], 0);
    chk("rst_my", m_y[0], 0);
    chk("rst_last", m_last[3], 0);
    reset = 1'b0;
    scan(0, -1, -1, dc, nb, fc, lc);
    chk("a_done_cycle", dc, 49);
    chk("a_beats", nb, 16);
    chk("a_first", fc, 3);
    chk("a_span", lc - fc, 45);
    chk("a_beat0", bdata[0], 32'h3FEF5C29);
    chk("a_beat5", bdata[5], 32'h3FEF5D2A);
    chk("a_beat15", bdata[15], 32'h3FEF5F2C);
    chk("a_last_map", blast, 16'h8000);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("done_start_busy", busy[0], 0);
    chk("done_start_rdn", rdn[0], 1);
    chk("done_start_done", done[0], 0);
    scan(0, 3, 5, dc, nb, fc, lc);
    chk("bp_done_cycle", dc, 54);
    chk("bp_beats", nb, 16);
    chk("bp_span", lc - fc, 50);
    chk("bp_beat3", bdata[3], 32'h3FEF5C2C);
    step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int t = 0; t < 100 && !(m_valid[0] && m_x[0] == 3 && m_y[0] == 1); t++) step();
    chk("mid_beat7", m_valid[0] && m_x[0] == 3 && m_y[0] == 1, 1);
    reset = 1'b1;
    step();
    chk("mid_rdn", rdn[0], 1);
    chk("mid_busy", busy[0], 0);
    chk("mid_valid", m_valid[0], 0);
    chk("mid_x", x_position[0], 0);
    chk("mid_y", y_position[0], 0);
    chk("mid_data", m_data[0], 0);
    chk("mid_mpos", {m_x[0], m_y[0]}, 0);
    chk("mid_last", m_last[0], 0);
    chk("mid_done", done[0], 0);
    reset = 1'b0;
    scan(0, -1, -1, dc, nb, fc, lc);
    chk("re_done_cycle", dc, 49);
    chk("re_beats", nb, 16);
    chk("re_beat0", bdata[0], 32'h3FEF5C29);
    step();
    scan(1, -1, -1, dc, nb, fc, lc);
    chk("l0_done_cycle", dc, 33);
    chk("l0_beats", nb, 16);
    chk("l0_first", fc, 2);
    chk("l0_span", lc - fc, 30);
    chk("l0_beat6", bdata[6], 32'h3FEF5D2B);
    step();
    scan(2, -1, -1, dc, nb, fc, lc);
    chk("l3_done_cycle", dc, 81);
    chk("l3_beats", nb, 16);
    chk("l3_first", fc, 5);
    chk("l3_span", lc - fc, 75);
    chk("l3_beat9", bdata[9], 32'h3FEF5E2A);
    step();
    scan(3, -1, -1, dc, nb, fc, lc);
    chk("one_done_cycle", dc, 4);
    chk("one_beats", nb, 1);
    chk("one_data", bdata[0], 32'h3FEF5C29);
    chk("one_last", blast, 16'h0001);
    step();
    chk("one_idle", busy[3], 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
